// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared image-processing types and defaults
package img_proc_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-line pixel store, asynchronous read-before-write at addr
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // No reset: contents are always rewritten while a frame primes.
  logic [WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - raster-stream 3x3 window generator for interior pixel centers
module window_3x3_gen
  import img_proc_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] z0,
  output logic [PIX_W-1:0] z1,
  output logic [PIX_W-1:0] z2,
  output logic [PIX_W-1:0] z3,
  output logic [PIX_W-1:0] z4,
  output logic [PIX_W-1:0] z5,
  output logic [PIX_W-1:0] z6,
  output logic [PIX_W-1:0] z7,
  output logic [PIX_W-1:0] z8,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_t state, next_state;

  logic [CW-1:0] col_cnt, cur_col;
  logic [RW-1:0] row_cnt, cur_row;
  logic start, accept, col_wrap, frame_end, emit;

  logic [PIX_W-1:0] lb0_q, lb1_q;
  logic [PIX_W-1:0] top_1, top_2, mid_1, mid_2, bot_1, bot_2;

  // A sof pixel is always taken as (0,0), whatever state the frame is in.
  always_comb begin
    start     = pix_valid & sof;
    accept    = pix_valid & (sof | (state == PRIME) | (state == ACTIVE));
    cur_col   = start ? '0 : col_cnt;
    cur_row   = start ? '0 : row_cnt;
    col_wrap  = (cur_col == COL_LAST);
    frame_end = col_wrap & (cur_row == ROW_LAST);
    emit      = accept & (cur_row >= ROW_TWO) & (cur_col >= COL_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = PRIME;
      end
      PRIME: begin
        if (start) next_state = PRIME;
        else if (accept && col_wrap && cur_row == ROW_ONE) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (start) next_state = PRIME;
        else if (accept && frame_end) next_state = DONE;
      end
      DONE: begin
        next_state = start ? PRIME : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      col_cnt <= col_wrap ? '0 : cur_col + 1'b1;
      if (col_wrap) begin
        row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        row_cnt <= cur_row;
      end
    end
  end

  // lb0 holds the previous line, lb1 the line before that.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
    .clk  (clk),
    .wr_en(accept),
    .addr (cur_col),
    .din  (pix_in),
    .dout (lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .clk  (clk),
    .wr_en(accept),
    .addr (cur_col),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      {top_1, top_2, mid_1, mid_2, bot_1, bot_2} <= '0;
    end else if (accept) begin
      top_2 <= top_1;
      top_1 <= lb1_q;
      mid_2 <= mid_1;
      mid_1 <= lb0_q;
      bot_2 <= bot_1;
      bot_1 <= pix_in;
    end
  end

  // Emission gated on column >= 2 keeps windows from straddling two lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      {z0, z1, z2, z3, z4, z5, z6, z7, z8} <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= (state == DONE);
      if (emit) begin
        z0 <= top_2;
        z1 <= top_1;
        z2 <= lb1_q;
        z3 <= mid_2;
        z4 <= mid_1;
        z5 <= lb0_q;
        z6 <= bot_2;
        z7 <= bot_1;
        z8 <= pix_in;
      end
    end
  end

endmodule
